// File: rtl/usb_cmd_frame_parser.sv
// Recovers 2-word register-write frames from the FT60x word stream and queues them (FWFT, valid/ready).
// Command visible one cycle after its trailer word; a push into a full queue without a same-cycle pop is dropped and counted.
module usb_cmd_frame_parser #(
   parameter int          DEPTH   = 4,
   parameter logic [15:0] HEADER  = 16'hA56B,
   parameter logic [15:0] TRAILER = 16'h7CD8,
   parameter int          TIMEOUT = 1024
) (
   input  logic        CLK_i,
   input  logic        Rstn_i,
   input  logic [31:0] rx_data_i,
   input  logic [3:0]  rx_be_i,
   input  logic        rx_valid_i,
   output logic        cmd_valid_o,
   input  logic        cmd_ready_i,
   output logic [15:0] cmd_addr_o,
   output logic [15:0] cmd_data_o,
   output logic [15:0] frame_cnt_o,
   output logic [7:0]  err_cnt_o,
   output logic [7:0]  ovf_cnt_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {HUNT, W1} state_t;

   state_t      state;
   logic [15:0] tmo_cnt;
   logic [15:0] addr_lat;
   logic        push;
   logic [15:0] push_addr;
   logic [15:0] push_data;

   logic [15:0] mem_addr [DEPTH];
   logic [15:0] mem_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic        word_good;
   logic [15:0] field_lo;
   logic [15:0] field_hi;
   logic        pop;
   logic        full;
   logic        accept;

   // Wire bytes arrive little-endian; each 16-bit field is byte-swapped.
   assign field_lo  = {rx_data_i[7:0],   rx_data_i[15:8]};
   assign field_hi  = {rx_data_i[23:16], rx_data_i[31:24]};
   assign word_good = (rx_be_i == 4'hF);

   assign cmd_valid_o = (count != '0);
   assign cmd_addr_o  = mem_addr[rd_ptr];
   assign cmd_data_o  = mem_data[rd_ptr];

   assign pop    = cmd_valid_o & cmd_ready_i;
   assign full   = (count == (AW+1)'(DEPTH));
   assign accept = push & (~full | pop);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge CLK_i or negedge Rstn_i) begin
      if (!Rstn_i) begin
         state     <= HUNT;
         tmo_cnt   <= '0;
         addr_lat  <= '0;
         push      <= 1'b0;
         push_addr <= '0;
         push_data <= '0;
         err_cnt_o <= '0;
      end else begin
         push <= 1'b0;
         case (state)
            HUNT: begin
               if (rx_valid_i && word_good && field_lo == HEADER) begin
                  addr_lat <= field_hi;
                  tmo_cnt  <= '0;
                  state    <= W1;
               end
            end
            W1: begin
               if (rx_valid_i) begin
                  if (word_good && field_hi == TRAILER) begin
                     push      <= 1'b1;
                     push_addr <= addr_lat;
                     push_data <= field_lo;
                  end else begin
                     err_cnt_o <= sat_inc(err_cnt_o);
                  end
                  state <= HUNT;
               end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                  // This idle cycle is the TIMEOUT-th one since the header.
                  err_cnt_o <= sat_inc(err_cnt_o);
                  state     <= HUNT;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   always_ff @(posedge CLK_i or negedge Rstn_i) begin
      if (!Rstn_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_addr[i] <= '0;
            mem_data[i] <= '0;
         end
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         frame_cnt_o <= '0;
         ovf_cnt_o   <= '0;
      end else begin
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push) begin
            if (accept) begin
               mem_addr[wr_ptr] <= push_addr;
               mem_data[wr_ptr] <= push_data;
               wr_ptr           <= wr_ptr + 1'b1;
               frame_cnt_o      <= frame_cnt_o + 16'd1;
            end else begin
               ovf_cnt_o <= sat_inc(ovf_cnt_o);
            end
         end
         case ({accept, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Directed bench for usb_cmd_frame_parser: frame vector table plus multi-cycle corner sequences.
module tb_usb_cmd_frame_parser;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 1024;

   logic        CLK_i = 1'b0;
   logic        Rstn_i = 1'b0;
   logic [31:0] rx_data_i = '0;
   logic [3:0]  rx_be_i = '0;
   logic        rx_valid_i = 1'b0;
   logic        cmd_valid_o;
   logic        cmd_ready_i = 1'b1;
   logic [15:0] cmd_addr_o;
   logic [15:0] cmd_data_o;
   logic [15:0] frame_cnt_o;
   logic [7:0]  err_cnt_o;
   logic [7:0]  ovf_cnt_o;

   usb_cmd_frame_parser #(
      .DEPTH(DEPTH), .HEADER(16'hA56B), .TRAILER(16'h7CD8), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK_i(CLK_i), .Rstn_i(Rstn_i),
      .rx_data_i(rx_data_i), .rx_be_i(rx_be_i), .rx_valid_i(rx_valid_i),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
      .cmd_addr_o(cmd_addr_o), .cmd_data_o(cmd_data_o),
      .frame_cnt_o(frame_cnt_o), .err_cnt_o(err_cnt_o), .ovf_cnt_o(ovf_cnt_o)
   );

   always #5 CLK_i = ~CLK_i;

   int checks = 0;
   int errors = 0;
   logic [7:0]  exp_err = '0;
   logic [15:0] exp_frame = '0;

   typedef struct {
      string       name;
      logic [31:0] w0;
      logic [3:0]  be0;
      logic [31:0] w1;
      logic [3:0]  be1;
      logic        exp_push;
      logic [15:0] exp_addr;
      logic [15:0] exp_data;
      logic        exp_err_inc;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK_i);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input logic [3:0] be);
      rx_data_i  = w;
      rx_be_i    = be;
      rx_valid_i = 1'b1;
      step();
      rx_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      rx_valid_i = 1'b0;
      repeat (n) step();
   endtask

   function automatic logic [15:0] swap16(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   function automatic logic [31:0] mk_w0(input logic [15:0] addr);
      return {swap16(addr), 16'h6BA5};
   endfunction

   function automatic logic [31:0] mk_w1(input logic [15:0] data);
      return {16'hD87C, swap16(data)};
   endfunction

   task automatic chk_counters(input string tag);
      chk({tag, "_err"},   {24'd0, err_cnt_o},   {24'd0, exp_err});
      chk({tag, "_frame"}, {16'd0, frame_cnt_o}, {16'd0, exp_frame});
   endtask

   initial begin
      vecs[0] = '{"single",   32'h3412_6BA5, 4'hF, 32'hD87C_CDAB, 4'hF, 1'b1, 16'h1234, 16'hABCD, 1'b0};
      vecs[1] = '{"zero_adr", 32'h0000_6BA5, 4'hF, 32'hD87C_FFFF, 4'hF, 1'b1, 16'h0000, 16'hFFFF, 1'b0};
      vecs[2] = '{"bad_trl",  32'h3412_6BA5, 4'hF, 32'hD97C_1111, 4'hF, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vecs[3] = '{"trl_be7",  32'h3412_6BA5, 4'hF, 32'hD87C_CDAB, 4'h7, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vecs[4] = '{"hdr_beE",  32'h3412_6BA5, 4'hE, 32'hD87C_CDAB, 4'hF, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vecs[5] = '{"hdr_mis",  32'h3412_6BA6, 4'hF, 32'hD87C_CDAB, 4'hF, 1'b0, 16'h0000, 16'h0000, 1'b0};
      vecs[6] = '{"beef",     32'hEFBE_6BA5, 4'hF, 32'hD87C_4200, 4'hF, 1'b1, 16'hBEEF, 16'h0042, 1'b0};
      vecs[7] = '{"trl_be0",  32'h7856_6BA5, 4'hF, 32'hD87C_2211, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b1};
      vecs[8] = '{"all_ones", 32'hFFFF_6BA5, 4'hF, 32'hD87C_0180, 4'hF, 1'b1, 16'hFFFF, 16'h8001, 1'b0};

      // Reset state
      step();
      chk("rst_valid", {31'd0, cmd_valid_o}, 32'd0);
      chk("rst_addr",  {16'd0, cmd_addr_o},  32'd0);
      chk("rst_data",  {16'd0, cmd_data_o},  32'd0);
      chk("rst_ovf",   {24'd0, ovf_cnt_o},   32'd0);
      chk_counters("rst");
      Rstn_i = 1'b1;
      step();

      // Frame vector table, ready held high
      cmd_ready_i = 1'b1;
      foreach (vecs[i]) begin
         send_word(vecs[i].w0, vecs[i].be0);
         send_word(vecs[i].w1, vecs[i].be1);
         idle(1);
         if (vecs[i].exp_push) exp_frame++;
         if (vecs[i].exp_err_inc) exp_err++;
         chk({vecs[i].name, "_valid"}, {31'd0, cmd_valid_o}, {31'd0, vecs[i].exp_push});
         if (vecs[i].exp_push) begin
            chk({vecs[i].name, "_addr"}, {16'd0, cmd_addr_o}, {16'd0, vecs[i].exp_addr});
            chk({vecs[i].name, "_data"}, {16'd0, cmd_data_o}, {16'd0, vecs[i].exp_data});
         end
         chk_counters(vecs[i].name);
         idle(1);
         chk({vecs[i].name, "_drain"}, {31'd0, cmd_valid_o}, 32'd0);
      end

      // Header followed by header: error, and the second word is not reused as a header
      send_word(32'h3412_6BA5, 4'hF);
      send_word(32'h3412_6BA5, 4'hF);
      send_word(32'hD87C_CDAB, 4'hF);
      idle(1);
      exp_err++;
      chk("hh_valid", {31'd0, cmd_valid_o}, 32'd0);
      chk_counters("hh");
      send_word(mk_w0(16'h0A0B), 4'hF);
      send_word(mk_w1(16'h0C0D), 4'hF);
      idle(1);
      exp_frame++;
      chk("hh_next_addr", {16'd0, cmd_addr_o}, 32'h0000_0A0B);
      chk("hh_next_data", {16'd0, cmd_data_o}, 32'h0000_0C0D);
      chk_counters("hh_next");
      idle(1);

      // Timeout boundary: TIMEOUT-1 idle cycles still accepted
      send_word(mk_w0(16'h1111), 4'hF);
      idle(TIMEOUT - 1);
      send_word(mk_w1(16'h2222), 4'hF);
      idle(1);
      exp_frame++;
      chk("tmo_edge_valid", {31'd0, cmd_valid_o}, 32'd1);
      chk("tmo_edge_addr", {16'd0, cmd_addr_o}, 32'h0000_1111);
      chk_counters("tmo_edge");
      idle(1);

      // Timeout: TIMEOUT idle cycles, late trailer ignored
      send_word(32'h3412_6BA5, 4'hF);
      idle(TIMEOUT);
      send_word(32'hD87C_CDAB, 4'hF);
      idle(1);
      exp_err++;
      chk("tmo_valid", {31'd0, cmd_valid_o}, 32'd0);
      chk_counters("tmo");

      // Garbage words in HUNT
      for (int i = 0; i < 10; i++) begin
         logic [31:0] w;
         w = $urandom;
         if (w[15:0] == 16'h6BA5) w[0] = 1'b0;
         send_word(w, 4'hF);
      end
      idle(2);
      chk("garb_valid", {31'd0, cmd_valid_o}, 32'd0);
      chk_counters("garb");

      // Back-pressure and overflow: 5 back-to-back frames into a 4-deep queue
      cmd_ready_i = 1'b0;
      for (int f = 0; f < 5; f++) begin
         send_word(mk_w0(16'h1000 + 16'(f)), 4'hF);
         send_word(mk_w1(16'h2000 + 16'(f)), 4'hF);
      end
      idle(1);
      exp_frame += 16'd4;
      chk("bp_valid", {31'd0, cmd_valid_o}, 32'd1);
      chk("bp_head_addr", {16'd0, cmd_addr_o}, 32'h0000_1000);
      chk("bp_head_data", {16'd0, cmd_data_o}, 32'h0000_2000);
      chk("bp_ovf", {24'd0, ovf_cnt_o}, 32'd1);
      chk_counters("bp");
      idle(3);
      chk("bp_stable_addr", {16'd0, cmd_addr_o}, 32'h0000_1000);
      chk("bp_stable_data", {16'd0, cmd_data_o}, 32'h0000_2000);
      cmd_ready_i = 1'b1;
      for (int f = 0; f < 4; f++) begin
         chk($sformatf("pop%0d_valid", f), {31'd0, cmd_valid_o}, 32'd1);
         chk($sformatf("pop%0d_addr", f), {16'd0, cmd_addr_o}, {16'd0, 16'h1000 + 16'(f)});
         chk($sformatf("pop%0d_data", f), {16'd0, cmd_data_o}, {16'd0, 16'h2000 + 16'(f)});
         step();
      end
      chk("pop_empty", {31'd0, cmd_valid_o}, 32'd0);

      // Reset with 3 queued entries and FSM in W1
      cmd_ready_i = 1'b0;
      for (int f = 0; f < 3; f++) begin
         send_word(mk_w0(16'h3000 + 16'(f)), 4'hF);
         send_word(mk_w1(16'h3100 + 16'(f)), 4'hF);
      end
      idle(1);
      send_word(mk_w0(16'h3333), 4'hF);
      chk("pre_rst_valid", {31'd0, cmd_valid_o}, 32'd1);
      #2 Rstn_i = 1'b0;
      #1;
      exp_err   = '0;
      exp_frame = '0;
      chk("mrst_valid", {31'd0, cmd_valid_o}, 32'd0);
      chk("mrst_ovf", {24'd0, ovf_cnt_o}, 32'd0);
      chk_counters("mrst");
      step();
      Rstn_i = 1'b1;
      send_word(32'hD87C_CDAB, 4'hF);
      idle(1);
      chk("post_rst_trl_valid", {31'd0, cmd_valid_o}, 32'd0);
      chk_counters("post_rst_trl");
      send_word(32'h4444_6BA5, 4'hF);
      send_word(32'hD87C_5555, 4'hF);
      idle(1);
      exp_frame++;
      chk("post_rst_valid", {31'd0, cmd_valid_o}, 32'd1);
      chk("post_rst_addr", {16'd0, cmd_addr_o}, 32'h0000_4444);
      chk("post_rst_data", {16'd0, cmd_data_o}, 32'h0000_5555);
      chk_counters("post_rst");
      cmd_ready_i = 1'b1;
      step();
      chk("post_rst_alone", {31'd0, cmd_valid_o}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
